// File: rtl/rf_wb_scheduler_pkg.sv
// ============================================================================
// Module : rf_pkg
// Brief  : Shared types and constants for the register-file write-back scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LSU  = 2'd2
    } arb_sel_e;

endpackage

`default_nettype wire

// File: rtl/rf_wb_scheduler_if.sv
// ============================================================================
// Module : rf_wb_if
// Brief  : Issue, execution-unit result and RF write-port bundle for the scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    logic            iss_valid;
    logic            iss_we;
    logic [4:0]      iss_rd;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic            iss_stall;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_done;
    logic [NREG-1:0] busy_map;
    logic            sb_err;

    modport master (
        output iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_stall, alu_ready, lsu_ready,
        input  rf_we, rf_waddr, rf_wdata, wb_done, busy_map, sb_err
    );

    modport slave (
        input  iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_stall, alu_ready, lsu_ready,
        output rf_we, rf_waddr, rf_wdata, wb_done, busy_map, sb_err
    );
endinterface

`default_nettype wire

// File: rtl/rf_wb_scheduler_arb.sv
// ============================================================================
// Module : rf_wb_arb
// Brief  : Two-way write-port arbiter (ALU/LSU), fixed LSU priority or round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arb #(
    parameter int ARB_RR = 0
) (
    input  wire                logic clk,
    input  wire                logic rst,
    input  wire                logic i_alu_valid,
    input  wire                logic i_lsu_valid,
    output rf_pkg::arb_sel_e   o_sel,
    output logic               o_alu_ready,
    output logic               o_lsu_ready
);
    import rf_pkg::*;

    logic w_alu_req;
    logic w_lsu_req;
    logic w_contended;
    logic w_prefer_alu;
    logic r_ptr_alu;

    // Requests seen while in reset must never be granted.
    assign w_alu_req   = i_alu_valid & ~rst;
    assign w_lsu_req   = i_lsu_valid & ~rst;
    assign w_contended = w_alu_req & w_lsu_req;

    assign w_prefer_alu = (ARB_RR != 0) ? r_ptr_alu : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_alu <= 1'b1;
        end else if (w_contended) begin
            r_ptr_alu <= ~r_ptr_alu;
        end
    end

    always_comb begin
        o_sel = SEL_NONE;
        if (w_contended) begin
            o_sel = w_prefer_alu ? SEL_ALU : SEL_LSU;
        end else if (w_alu_req) begin
            o_sel = SEL_ALU;
        end else if (w_lsu_req) begin
            o_sel = SEL_LSU;
        end
    end

    assign o_alu_ready = (o_sel == SEL_ALU);
    assign o_lsu_ready = (o_sel == SEL_LSU);

endmodule

`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
// ============================================================================
// Module : rf_wb_scheduler
// Brief  : RF write-back scheduler + RAW/WAW scoreboard with registered write port.
//          Optional macro RF_SB_STALL_CNT_EN adds a saturating stall counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_scheduler #(
    parameter int NREG   = 32,
    parameter int XLEN   = 32,
    parameter int ARB_RR = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
`ifdef RF_SB_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    rf_wb_if.slave      bus
);
    import rf_pkg::*;

    wb_req_t         w_alu_req;
    wb_req_t         w_lsu_req;
    wb_req_t         w_win;
    arb_sel_e        w_sel;
    logic            w_alu_ready;
    logic            w_lsu_ready;
    logic            w_grant;
    logic            w_stall;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;

    logic [NREG-1:0] r_busy;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_wb_done;
    logic            r_sb_err;

    assign w_alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
    assign w_lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

    rf_wb_arb #(
        .ARB_RR (ARB_RR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_alu_valid (w_alu_req.valid),
        .i_lsu_valid (w_lsu_req.valid),
        .o_sel       (w_sel),
        .o_alu_ready (w_alu_ready),
        .o_lsu_ready (w_lsu_ready)
    );

    always_comb begin
        w_win = '0;
        case (w_sel)
            SEL_ALU: w_win = w_alu_req;
            SEL_LSU: w_win = w_lsu_req;
            default: w_win = '0;
        endcase
    end

    assign w_grant = (w_sel != SEL_NONE);

    assign w_stall = bus.iss_valid &
                     (r_busy[bus.iss_rs1] | r_busy[bus.iss_rs2] |
                      (bus.iss_we & r_busy[bus.iss_rd]));

    // Clear tracks the registered commit so the scoreboard and RF update together.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.iss_valid && !w_stall && bus.iss_we && (bus.iss_rd != ZERO_REG)) begin
            w_set[bus.iss_rd] = 1'b1;
        end
        if (r_rf_we) begin
            w_clr[r_rf_waddr] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_wb_done  <= 1'b0;
            r_sb_err   <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_rf_we   <= w_grant && (w_win.rd != ZERO_REG);
            r_wb_done <= w_grant;
            if (w_grant) begin
                r_rf_waddr <= w_win.rd;
                r_rf_wdata <= w_win.data;
            end
            if (r_rf_we && !r_busy[r_rf_waddr]) begin
                r_sb_err <= 1'b1;
            end
        end
    end

`ifdef RF_SB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.iss_stall = w_stall;
    assign bus.alu_ready = w_alu_ready;
    assign bus.lsu_ready = w_lsu_ready;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.wb_done   = r_wb_done;
    assign bus.busy_map  = r_busy;
    assign bus.sb_err    = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
// ============================================================================
// Module : tb_rf_wb_scheduler
// Brief  : Directed self-checking bench; fixed-priority and round-robin instances.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rf_wb_if bus_fp ();
    rf_wb_if bus_rr ();

`ifdef RF_SB_STALL_CNT_EN
    logic [15:0] stall_cnt_fp;
    logic [15:0] stall_cnt_rr;
`endif

    rf_wb_scheduler #(.NREG(32), .XLEN(32), .ARB_RR(0)) dut_fp (
        .clk       (clk),
        .rst       (rst),
`ifdef RF_SB_STALL_CNT_EN
        .stall_cnt (stall_cnt_fp),
`endif
        .bus       (bus_fp.slave)
    );

    rf_wb_scheduler #(.NREG(32), .XLEN(32), .ARB_RR(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
`ifdef RF_SB_STALL_CNT_EN
        .stall_cnt (stall_cnt_rr),
`endif
        .bus       (bus_rr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_fp.iss_valid = 0; bus_fp.iss_we = 0; bus_fp.iss_rd = 0; bus_fp.iss_rs1 = 0; bus_fp.iss_rs2 = 0;
        bus_fp.alu_valid = 0; bus_fp.alu_rd = 0; bus_fp.alu_data = 0;
        bus_fp.lsu_valid = 0; bus_fp.lsu_rd = 0; bus_fp.lsu_data = 0;
        bus_rr.iss_valid = 0; bus_rr.iss_we = 0; bus_rr.iss_rd = 0; bus_rr.iss_rs1 = 0; bus_rr.iss_rs2 = 0;
        bus_rr.alu_valid = 0; bus_rr.alu_rd = 0; bus_rr.alu_data = 0;
        bus_rr.lsu_valid = 0; bus_rr.lsu_rd = 0; bus_rr.lsu_data = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        bus_fp.alu_valid = 1; bus_fp.alu_rd = 5'd1; bus_fp.alu_data = 32'h11;
        bus_fp.lsu_valid = 1; bus_fp.lsu_rd = 5'd2; bus_fp.lsu_data = 32'h22;
        step();
        step();
        @(negedge clk);
        checks++; if (bus_fp.alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%b exp=0", bus_fp.alu_ready); end
        checks++; if (bus_fp.lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_lsu_ready got=%b exp=0", bus_fp.lsu_ready); end
        checks++; if (bus_fp.rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", bus_fp.rf_we); end
        checks++; if (bus_fp.wb_done !== 1'b0) begin failures++; $display("FAIL reset_wb_done got=%b exp=0", bus_fp.wb_done); end
        checks++; if (bus_fp.busy_map !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus_fp.busy_map); end
        checks++; if (bus_fp.sb_err !== 1'b0) begin failures++; $display("FAIL reset_sb_err got=%b exp=0", bus_fp.sb_err); end
        checks++; if (bus_fp.rf_waddr !== 5'd0 || bus_fp.rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_waddr_wdata got=%h/%h exp=0/0", bus_fp.rf_waddr, bus_fp.rf_wdata); end
        step();
        rst = 0;
        @(negedge clk);
        checks++; if (bus_fp.lsu_ready !== 1'b1 || bus_fp.alu_ready !== 1'b0) begin failures++; $display("FAIL post_reset_grant got=lsu%b alu%b exp=lsu1 alu0", bus_fp.lsu_ready, bus_fp.alu_ready); end
        step();
        bus_fp.alu_valid = 0; bus_fp.lsu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.rf_we !== 1'b1 || bus_fp.rf_waddr !== 5'd2 || bus_fp.rf_wdata !== 32'h22) begin failures++; $display("FAIL post_reset_commit got=%b/%h/%h exp=1/02/22", bus_fp.rf_we, bus_fp.rf_waddr, bus_fp.rf_wdata); end
    endtask

    task automatic test_raw();
        apply_reset();
        bus_fp.iss_valid = 1; bus_fp.iss_we = 1; bus_fp.iss_rd = 5'd5;
        @(negedge clk);
        checks++; if (bus_fp.iss_stall !== 1'b0) begin failures++; $display("FAIL raw_first_issue_stall got=%b exp=0", bus_fp.iss_stall); end
        step();
        bus_fp.iss_we = 0; bus_fp.iss_rd = 5'd6; bus_fp.iss_rs1 = 5'd5;
        bus_fp.alu_valid = 1; bus_fp.alu_rd = 5'd5; bus_fp.alu_data = 32'd1000;
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h20) begin failures++; $display("FAIL raw_busy got=%h exp=00000020", bus_fp.busy_map); end
        checks++; if (bus_fp.iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", bus_fp.iss_stall); end
        checks++; if (bus_fp.alu_ready !== 1'b1) begin failures++; $display("FAIL raw_alu_ready got=%b exp=1", bus_fp.alu_ready); end
        step();
        bus_fp.alu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.rf_we !== 1'b1 || bus_fp.rf_waddr !== 5'd5 || bus_fp.rf_wdata !== 32'd1000) begin failures++; $display("FAIL raw_commit got=%b/%0d/%0d exp=1/5/1000", bus_fp.rf_we, bus_fp.rf_waddr, bus_fp.rf_wdata); end
        checks++; if (bus_fp.wb_done !== 1'b1) begin failures++; $display("FAIL raw_wb_done got=%b exp=1", bus_fp.wb_done); end
        checks++; if (bus_fp.iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_commit_cycle got=%b exp=1", bus_fp.iss_stall); end
        step();
        @(negedge clk);
        checks++; if (bus_fp.iss_stall !== 1'b0) begin failures++; $display("FAIL raw_unstall got=%b exp=0", bus_fp.iss_stall); end
        checks++; if (bus_fp.busy_map !== 32'h0) begin failures++; $display("FAIL raw_busy_clear got=%h exp=0", bus_fp.busy_map); end
        checks++; if (bus_fp.rf_we !== 1'b0 || bus_fp.wb_done !== 1'b0) begin failures++; $display("FAIL raw_pulse_width got=%b/%b exp=0/0", bus_fp.rf_we, bus_fp.wb_done); end
        checks++; if (bus_fp.sb_err !== 1'b0) begin failures++; $display("FAIL raw_sb_err got=%b exp=0", bus_fp.sb_err); end
        bus_fp.iss_valid = 0;
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        bus_fp.iss_valid = 1; bus_fp.iss_we = 1; bus_fp.iss_rd = 5'd3;
        step();
        bus_fp.iss_rd = 5'd4;
        step();
        bus_fp.iss_valid = 0; bus_fp.iss_we = 0;
        bus_fp.alu_valid = 1; bus_fp.alu_rd = 5'd3; bus_fp.alu_data = 32'd33;
        bus_fp.lsu_valid = 1; bus_fp.lsu_rd = 5'd4; bus_fp.lsu_data = 32'd44;
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h18) begin failures++; $display("FAIL fp_busy got=%h exp=00000018", bus_fp.busy_map); end
        checks++; if (bus_fp.lsu_ready !== 1'b1 || bus_fp.alu_ready !== 1'b0) begin failures++; $display("FAIL fp_first_grant got=lsu%b alu%b exp=lsu1 alu0", bus_fp.lsu_ready, bus_fp.alu_ready); end
        step();
        bus_fp.lsu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.alu_ready !== 1'b1) begin failures++; $display("FAIL fp_second_grant got=%b exp=1", bus_fp.alu_ready); end
        checks++; if (bus_fp.rf_we !== 1'b1 || bus_fp.rf_waddr !== 5'd4 || bus_fp.rf_wdata !== 32'd44) begin failures++; $display("FAIL fp_commit_x4 got=%b/%0d/%0d exp=1/4/44", bus_fp.rf_we, bus_fp.rf_waddr, bus_fp.rf_wdata); end
        step();
        bus_fp.alu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.rf_we !== 1'b1 || bus_fp.rf_waddr !== 5'd3 || bus_fp.rf_wdata !== 32'd33) begin failures++; $display("FAIL fp_commit_x3 got=%b/%0d/%0d exp=1/3/33", bus_fp.rf_we, bus_fp.rf_waddr, bus_fp.rf_wdata); end
        step();
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h0 || bus_fp.sb_err !== 1'b0) begin failures++; $display("FAIL fp_final got=%h/%b exp=0/0", bus_fp.busy_map, bus_fp.sb_err); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_addr;
        logic       exp_alu;
        apply_reset();
        bus_rr.alu_valid = 1; bus_rr.alu_rd = 5'd10; bus_rr.alu_data = 32'hA0;
        bus_rr.lsu_valid = 1; bus_rr.lsu_rd = 5'd11; bus_rr.lsu_data = 32'hB0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                bus_rr.alu_valid = 0; bus_rr.lsu_valid = 0;
            end
            @(negedge clk);
            if (k < 4) begin
                exp_alu = (k % 2 == 0);
                checks++; if (bus_rr.alu_ready !== exp_alu || bus_rr.lsu_ready !== ~exp_alu) begin failures++; $display("FAIL rr_grant_%0d got=alu%b lsu%b exp=alu%b lsu%b", k, bus_rr.alu_ready, bus_rr.lsu_ready, exp_alu, ~exp_alu); end
            end
            if (k > 0) begin
                exp_addr = ((k - 1) % 2 == 0) ? 5'd10 : 5'd11;
                checks++; if (bus_rr.rf_we !== 1'b1 || bus_rr.rf_waddr !== exp_addr) begin failures++; $display("FAIL rr_commit_%0d got=%b/%0d exp=1/%0d", k, bus_rr.rf_we, bus_rr.rf_waddr, exp_addr); end
            end
            step();
        end
    endtask

    task automatic test_x0_and_err();
        apply_reset();
        bus_fp.iss_valid = 1; bus_fp.iss_we = 1; bus_fp.iss_rd = 5'd0;
        @(negedge clk);
        checks++; if (bus_fp.iss_stall !== 1'b0) begin failures++; $display("FAIL x0_issue_stall got=%b exp=0", bus_fp.iss_stall); end
        step();
        bus_fp.iss_valid = 0; bus_fp.iss_we = 0;
        bus_fp.alu_valid = 1; bus_fp.alu_rd = 5'd0; bus_fp.alu_data = 32'hDEAD;
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h0) begin failures++; $display("FAIL x0_busy got=%h exp=0", bus_fp.busy_map); end
        checks++; if (bus_fp.alu_ready !== 1'b1) begin failures++; $display("FAIL x0_alu_ready got=%b exp=1", bus_fp.alu_ready); end
        step();
        bus_fp.alu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.wb_done !== 1'b1 || bus_fp.rf_we !== 1'b0) begin failures++; $display("FAIL x0_commit got=done%b we%b exp=done1 we0", bus_fp.wb_done, bus_fp.rf_we); end
        step();
        bus_fp.lsu_valid = 1; bus_fp.lsu_rd = 5'd7; bus_fp.lsu_data = 32'h77;
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h0 || bus_fp.sb_err !== 1'b0) begin failures++; $display("FAIL x0_no_side_effect got=%h/%b exp=0/0", bus_fp.busy_map, bus_fp.sb_err); end
        checks++; if (bus_fp.lsu_ready !== 1'b1) begin failures++; $display("FAIL err_lsu_ready got=%b exp=1", bus_fp.lsu_ready); end
        step();
        bus_fp.lsu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.rf_we !== 1'b1 || bus_fp.rf_waddr !== 5'd7 || bus_fp.rf_wdata !== 32'h77) begin failures++; $display("FAIL err_commit got=%b/%0d/%h exp=1/7/77", bus_fp.rf_we, bus_fp.rf_waddr, bus_fp.rf_wdata); end
        step();
        @(negedge clk);
        checks++; if (bus_fp.sb_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus_fp.sb_err); end
        step();
        step();
        @(negedge clk);
        checks++; if (bus_fp.sb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus_fp.sb_err); end
        apply_reset();
        @(negedge clk);
        checks++; if (bus_fp.sb_err !== 1'b0) begin failures++; $display("FAIL err_reset_clear got=%b exp=0", bus_fp.sb_err); end
    endtask

    task automatic test_waw_reset();
        apply_reset();
        bus_fp.iss_valid = 1; bus_fp.iss_we = 1; bus_fp.iss_rd = 5'd9;
        step();
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h200) begin failures++; $display("FAIL waw_busy got=%h exp=00000200", bus_fp.busy_map); end
        checks++; if (bus_fp.iss_stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", bus_fp.iss_stall); end
        step();
        rst = 1;
        bus_fp.alu_valid = 1; bus_fp.alu_rd = 5'd9; bus_fp.alu_data = 32'h99;
        @(negedge clk);
        checks++; if (bus_fp.alu_ready !== 1'b0) begin failures++; $display("FAIL waw_reset_no_grant got=%b exp=0", bus_fp.alu_ready); end
        step();
        rst = 0;
        bus_fp.alu_valid = 0;
        @(negedge clk);
        checks++; if (bus_fp.busy_map !== 32'h0) begin failures++; $display("FAIL waw_reset_busy got=%h exp=0", bus_fp.busy_map); end
        checks++; if (bus_fp.iss_stall !== 1'b0) begin failures++; $display("FAIL waw_reset_stall got=%b exp=0", bus_fp.iss_stall); end
        checks++; if (bus_fp.rf_we !== 1'b0 || bus_fp.wb_done !== 1'b0) begin failures++; $display("FAIL waw_reset_no_commit got=%b/%b exp=0/0", bus_fp.rf_we, bus_fp.wb_done); end
        step();
        bus_fp.iss_valid = 0; bus_fp.iss_we = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        idle_inputs();
        test_reset();
        test_raw();
        test_fixed_priority();
        test_round_robin();
        test_x0_and_err();
        test_waw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file (x0 hard-wired zero).
- Shares the RF's single write port between two requesters, ALU and load unit (LSU), with a registered write port.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards.
- Sits between decode/issue, the execution units, and the RF write port; replaces ad-hoc DONE_ALU/DONE_RF sequencing.

Parameters:
- NREG, 32, number of architectural registers (scoreboard width).
- XLEN, 32, data width.
- ARB_RR, 0, 0 = fixed priority (LSU over ALU); 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  issue slot holds an instruction
- iss_we  in  1  instruction writes rd
- iss_rd  in  5  destination address
- iss_rs1  in  5  source 1 address
- iss_rs2  in  5  source 2 address
- iss_stall  out  1  hazard; issue must hold
- alu_valid  in  1  ALU result request
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request granted this cycle
- lsu_valid  in  1  load result request
- lsu_rd  in  5  load destination
- lsu_data  in  XLEN  load data
- lsu_ready  out  1  LSU request granted this cycle
- rf_we  out  1  RF write enable (registered)
- rf_waddr  out  5  RF write address (registered)
- rf_wdata  out  XLEN  RF write data (registered)
- wb_done  out  1  one-cycle pulse per committed write (DONE_RF equivalent)
- busy_map  out  NREG  scoreboard, bit i = write to xi pending
- sb_err  out  1  sticky: commit to a non-pending register

Behaviour:
- Reset (sync, rst=1 at posedge): busy_map=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, sb_err=0, RR pointer=ALU. Requests present during reset are ignored, not granted. Reset mid-flight discards in-progress writes.
- Hazard detection (combinational):
  - iss_stall = iss_valid & (busy[rs1] | busy[rs2] | (iss_we & busy[rd])).
  - busy[0] is always 0.
- Issue accept = iss_valid & !iss_stall. On accept with iss_we=1 and rd!=0, set busy[rd] at the next edge.
- Arbitration (combinational grant, one per cycle):
  - ARB_RR=0: LSU wins when both requesters are valid.
  - ARB_RR=1: pointer alternates, and moves only on a contended grant.
  - A requester holds valid/rd/data stable until its ready is seen.
- Commit latency: the grant in cycle N gives rf_we/rf_waddr/rf_wdata/wb_done high in cycle N+1 for exactly one cycle.
- Clear timing: busy[rd] is cleared at the N+1 edge. The RF write and the clear are visible together, so a dependent issue unstalls in cycle N+2.
- rd=0 grant: request is consumed (ready=1), wb_done pulses, rf_we stays 0, no scoreboard change.
- Grant to rd with busy[rd]=0 (rd!=0): write still performed, sb_err set until reset.
- Same-edge set and clear of one register: clear applies first, then set (set wins). Cannot occur legally because of the WAW stall, but the rule is fixed.
- No buffering: a denied requester simply waits; no data is dropped.

Optional Feature:
- Macro RF_SB_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0], which increments each cycle iss_stall=1, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package rf_pkg:
  - REG_ADDR_W=5, XLEN=32, NREG=32, ZERO_REG=5'd0
  - typedef wb_req_t {valid, rd, data}
  - typedef enum arb_sel_e {SEL_NONE, SEL_ALU, SEL_LSU}
- One sub-module, rf_wb_arb: 2-way fixed/RR arbiter producing arb_sel_e plus ready signals.
- Scoreboard and commit register stay in the top module.

Test Plan:
- Reset: drive all requests high with rst=1 → no ready, rf_we=0, busy_map=0; after rst drops, grants begin the next cycle.
- RAW: issue rd=5 with iss_we → busy_map=32'h20; next issue rs1=5 stalls; ALU commits rd=5 data=1000 → rf_we/rf_waddr=5/rf_wdata=1000 one cycle after alu_ready; stall drops the cycle after that.
- Contention, ARB_RR=0: alu rd=3 and lsu rd=4 both valid → lsu_ready first, alu_ready next cycle → commits in order x4, x3.
- Contention, ARB_RR=1, both requesters held valid 4 cycles → grants alternate ALU, LSU, ALU, LSU.
- x0 and error: issue rd=0 → busy_map unchanged; ALU rd=0 → wb_done=1, rf_we=0; LSU commit to non-pending x7 → sb_err=1 and stays 1 until reset.
- WAW and reset mid-op: rd=9 pending, issue rd=9 → stalls; assert rst while the ALU request for x9 is valid → no grant, busy_map=0, stall released.
